// File: rtl/lockin_mixer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lockin_mixer
// Purpose  : Lock-in demodulation front stage. Each accepted ADC sample is
//            multiplied by an in-phase (sin) and a quadrature (cos) reference
//            value read from a writable table. The table is indexed by a
//            phase counter that advances once per accepted sample. The full
//            precision I/Q products are emitted on a valid-only stream.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock          in   1       system clock
//   reset          in   1       asynchronous active-low reset
//   data_valid     in   1       strobe qualifying data
//   data           in   Q_IN    signed ADC sample
//   ref_wr_en      in   1       reference table write strobe
//   ref_wr_addr    in   ADDR_W  table write address
//   ref_wr_sin     in   Q_REF   signed in-phase reference value
//   ref_wr_cos     in   Q_REF   signed quadrature reference value
//   period_len     in   ADDR_W  samples per reference period
//   phase_clear    in   1       synchronous strobe forcing phase to 0
//   data_out_i     out  Q_OUT   signed data*sin product
//   data_out_q     out  Q_OUT   signed data*cos product
//   data_out_valid out  1       strobe qualifying both outputs
//   sample_dropped out  1       strobe when a data_valid is ignored
// ============================================================================
module lockin_mixer #(
    parameter int Q_IN   = 24,
    parameter int Q_REF  = 16,
    parameter int Q_OUT  = 64,   // must be >= Q_IN + Q_REF
    parameter int ADDR_W = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    data_valid,
    input  logic signed [Q_IN-1:0]  data,
    input  logic                    ref_wr_en,
    input  logic [ADDR_W-1:0]       ref_wr_addr,
    input  logic signed [Q_REF-1:0] ref_wr_sin,
    input  logic signed [Q_REF-1:0] ref_wr_cos,
    input  logic [ADDR_W-1:0]       period_len,
    input  logic                    phase_clear,
    output logic signed [Q_OUT-1:0] data_out_i,
    output logic signed [Q_OUT-1:0] data_out_q,
    output logic                    data_out_valid,
    output logic                    sample_dropped
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PROD_W = Q_IN + Q_REF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_MULT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                     state_q,   state_d;
    logic signed [Q_IN-1:0]     x_q,       x_d;
    logic [ADDR_W-1:0]          addr_q,    addr_d;
    logic [ADDR_W-1:0]          phase_q,   phase_d;
    logic signed [Q_REF-1:0]    sin_q,     sin_d;
    logic signed [Q_REF-1:0]    cos_q,     cos_d;
    logic signed [PROD_W-1:0]   p_i_q,     p_i_d;
    logic signed [PROD_W-1:0]   p_q_q,     p_q_d;
    logic signed [Q_OUT-1:0]    out_i_q,   out_i_d;
    logic signed [Q_OUT-1:0]    out_q_q,   out_q_d;
    logic                       valid_q,   valid_d;
    logic                       dropped_q, dropped_d;

    // Reference table: no reset, contents undefined until written.
    logic signed [Q_REF-1:0]    tab_sin_mem [DEPTH];
    logic signed [Q_REF-1:0]    tab_cos_mem [DEPTH];

    logic [ADDR_W-1:0]          phase_adv;

    always_ff @(posedge clock) begin
        if (ref_wr_en) begin
            tab_sin_mem[ref_wr_addr] <= ref_wr_sin;
            tab_cos_mem[ref_wr_addr] <= ref_wr_cos;
        end
    end

    // Wrap on ">=" rather than "==" so that a period shortened below the
    // current phase returns to 0 on the very next advance.
    always_comb begin
        phase_adv = phase_q + ADDR_W'(1);
        if (period_len <= ADDR_W'(1)) begin
            phase_adv = '0;
        end else if (phase_q >= (period_len - ADDR_W'(1))) begin
            phase_adv = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        addr_d    = addr_q;
        phase_d   = phase_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        p_i_d     = p_i_q;
        p_q_d     = p_q_q;
        out_i_d   = out_i_q;
        out_q_d   = out_q_q;
        valid_d   = 1'b0;
        dropped_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (data_valid) begin
                    x_d     = data;
                    addr_d  = phase_q;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Array read sees the pre-edge contents, so a write to the
                // same address on this edge yields the old values.
                sin_d     = tab_sin_mem[addr_q];
                cos_d     = tab_cos_mem[addr_q];
                phase_d   = phase_adv;
                dropped_d = data_valid;
                state_d   = S_MULT;
            end
            S_MULT: begin
                p_i_d     = PROD_W'(x_q) * PROD_W'(sin_q);
                p_q_d     = PROD_W'(x_q) * PROD_W'(cos_q);
                dropped_d = data_valid;
                state_d   = S_OUTPUT;
            end
            S_OUTPUT: begin
                // Signed size cast sign-extends the product to Q_OUT bits.
                out_i_d   = Q_OUT'(p_i_q);
                out_q_d   = Q_OUT'(p_q_q);
                valid_d   = 1'b1;
                dropped_d = data_valid;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear wins over the FETCH advance; a latched address is untouched.
        if (phase_clear) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            addr_q    <= '0;
            phase_q   <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
            p_i_q     <= '0;
            p_q_q     <= '0;
            out_i_q   <= '0;
            out_q_q   <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            addr_q    <= addr_d;
            phase_q   <= phase_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            p_i_q     <= p_i_d;
            p_q_q     <= p_q_d;
            out_i_q   <= out_i_d;
            out_q_q   <= out_q_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign data_out_i     = out_i_q;
    assign data_out_q     = out_q_q;
    assign data_out_valid = valid_q;
    assign sample_dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_lockin_mixer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lockin_mixer
// Purpose  : Directed self-checking bench for lockin_mixer. Expected products
//            are computed from a bench-side copy of the reference table at the
//            address the bench expects the sample to use, then queued with the
//            cycle on which data_out_valid must be seen.
// Revision : 1.0  initial release
// ============================================================================
module tb_lockin_mixer;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               data_valid = 1'b0;
    logic signed [23:0] data = '0;
    logic               ref_wr_en = 1'b0;
    logic [5:0]         ref_wr_addr = '0;
    logic signed [15:0] ref_wr_sin = '0;
    logic signed [15:0] ref_wr_cos = '0;
    logic [5:0]         period_len = 6'd4;
    logic               phase_clear = 1'b0;
    logic signed [63:0] data_out_i;
    logic signed [63:0] data_out_q;
    logic               data_out_valid;
    logic               sample_dropped;

    lockin_mixer #(
        .Q_IN   (24),
        .Q_REF  (16),
        .Q_OUT  (64),
        .ADDR_W (6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_valid     (data_valid),
        .data           (data),
        .ref_wr_en      (ref_wr_en),
        .ref_wr_addr    (ref_wr_addr),
        .ref_wr_sin     (ref_wr_sin),
        .ref_wr_cos     (ref_wr_cos),
        .period_len     (period_len),
        .phase_clear    (phase_clear),
        .data_out_i     (data_out_i),
        .data_out_q     (data_out_q),
        .data_out_valid (data_out_valid),
        .sample_dropped (sample_dropped)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] ei;
        logic [63:0] eq;
        int          ecyc;
    } exp_t;

    exp_t               sb[$];
    logic signed [15:0] m_sin [64];
    logic signed [15:0] m_cos [64];
    int                 n_chk  = 0;
    int                 n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Output side of the scoreboard.
    always @(negedge clock) begin
        if (data_out_valid) begin
            chk("valid_has_expectation", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("data_out_i", data_out_i, e.ei);
                chk("data_out_q", data_out_q, e.eq);
                chk("valid_latency_cycle", 64'(cyc), 64'(e.ecyc));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input int addr, input logic signed [15:0] s, input logic signed [15:0] c);
        ref_wr_en   = 1'b1;
        ref_wr_addr = 6'(addr);
        ref_wr_sin  = s;
        ref_wr_cos  = c;
        @(posedge clock);
        #1;
        ref_wr_en   = 1'b0;
        m_sin[addr] = s;
        m_cos[addr] = c;
    endtask

    task automatic clear();
        phase_clear = 1'b1;
        @(posedge clock);
        #1;
        phase_clear = 1'b0;
    endtask

    // Drive one sample; addr is the table entry the sample must use.
    task automatic accept(input logic signed [23:0] d, input int addr, input bit push);
        exp_t e;
        data       = d;
        data_valid = 1'b1;
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        if (push) begin
            e.ei   = 64'(longint'(d) * longint'(m_sin[addr]));
            e.eq   = 64'(longint'(d) * longint'(m_cos[addr]));
            e.ecyc = cyc + 3;
            sb.push_back(e);
        end
    endtask

    logic signed [15:0] qs [4] = '{16'sd0, 16'sd100, 16'sd0, -16'sd100};
    logic signed [15:0] qc [4] = '{16'sd100, 16'sd0, -16'sd100, 16'sd0};
    int                 wrap_addr  [7] = '{0, 1, 2, 0, 1, 2, 0};
    int                 clear_addr [6] = '{0, 1, 2, 0, 1, 0};

    initial begin
        // Reset state
        idle(3);
        chk("reset_out_i",   data_out_i,             64'd0);
        chk("reset_out_q",   data_out_q,             64'd0);
        chk("reset_valid",   64'(data_out_valid),    64'd0);
        chk("reset_dropped", 64'(sample_dropped),    64'd0);
        reset = 1'b1;
        idle(2);

        // Quadrature table, period 4, one sample every 10 clocks
        for (int i = 0; i < 4; i++) wr(i, qs[i], qc[i]);
        period_len = 6'd4;
        for (int k = 0; k < 8; k++) begin
            accept(24'sd1000, k % 4, 1'b1);
            idle(9);
        end

        // Extremes: -2^23 * -2^15 = 2^38; (2^23-1) * -2^15 = -274877874176
        wr(0, 16'sh8000, 16'sh8000);
        wr(1, 16'sh8000, 16'sd0);
        clear();
        accept(24'sh800000, 0, 1'b1);
        idle(9);
        accept(24'sd8388607, 1, 1'b1);
        idle(9);

        // Drop: second data_valid lands on edge E2 (state MULT)
        wr(0, 16'sd0, 16'sd100);
        wr(1, 16'sd100, 16'sd0);
        clear();
        accept(24'sd1000, 0, 1'b1);
        idle(1);
        chk("dropped_before", 64'(sample_dropped), 64'd0);
        data       = 24'sd555;
        data_valid = 1'b1;
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        chk("dropped_pulse", 64'(sample_dropped), 64'd1);
        idle(1);
        chk("dropped_after", 64'(sample_dropped), 64'd0);
        idle(7);
        accept(24'sd1000, 1, 1'b1);
        idle(9);

        // Wrap with period 3
        wr(0, 16'sd10, -16'sd1);
        wr(1, 16'sd20, -16'sd2);
        wr(2, 16'sd30, -16'sd3);
        period_len = 6'd3;
        clear();
        for (int k = 0; k < 7; k++) begin
            accept(24'sd1000, wrap_addr[k], 1'b1);
            idle(9);
        end

        // phase_clear on the 5th sample's FETCH edge
        clear();
        for (int k = 0; k < 6; k++) begin
            accept(24'sd1000, clear_addr[k], 1'b1);
            if (k == 4) begin
                clear();
                idle(8);
            end else begin
                idle(9);
            end
        end

        // Reset while in MULT: sample abandoned, outputs cleared at once
        accept(24'sd1000, 0, 1'b0);
        idle(1);
        reset = 1'b0;
        #1;
        chk("midreset_out_i",   data_out_i,          64'd0);
        chk("midreset_out_q",   data_out_q,          64'd0);
        chk("midreset_valid",   64'(data_out_valid), 64'd0);
        chk("midreset_dropped", 64'(sample_dropped), 64'd0);
        idle(4);
        reset = 1'b1;
        idle(2);
        accept(24'sd7, 0, 1'b1);
        idle(9);

        // Write collision on the FETCH edge, then period_len = 1
        clear();
        accept(24'sd1000, 0, 1'b1);
        wr(0, 16'sd50, -16'sd50);
        idle(8);
        period_len = 6'd1;
        clear();
        accept(24'sd1000, 0, 1'b1);
        idle(9);
        accept(-24'sd3, 0, 1'b1);
        idle(9);

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clock);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
